// File: rtl/ext_bus_responder.sv
// External-bus slave: word-organised memory behind an en/we/size/addr/rdy handshake, plus a two-line interrupt handshake.
// Optional build macro EXT_BUS_RANDOM_WAIT_EN adds 0..3 LFSR-chosen extra wait states per transaction.
module ext_bus_responder #(
    parameter int MEM_WORDS   = 4096,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_en_i,
    input  logic                  bus_we_i,
    input  logic [1:0]            bus_size_i,
    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_data_oe_o,
    output logic                  bus_rdy_o,
    input  logic [1:0]            irq_trig_i,
    output logic [1:0]            intr_h_o,
    input  logic [1:0]            intr_ack_i,
    output logic                  err_o
);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] BYTE_SPAN = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state, state_nx;
    logic [4:0]            cnt, cnt_nx, wait_total;
    logic                  capture;

    logic                  req_we_p0;
    logic [1:0]            req_size_p0;
    logic [1:0]            req_off_p0;
    logic [IDX_W-1:0]      req_idx_p0;
    logic [DATA_WIDTH-1:0] req_data_p0;
    logic                  req_err_p0;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rd_word;

    function automatic logic access_err(input logic [1:0] size, input logic [ADDR_WIDTH-1:0] addr);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr[0];
            2'd2:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || (32'(addr) >= BYTE_SPAN);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_read(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0] size, input logic [1:0] off);
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    return DATA_WIDTH'(sh[7:0]);
            2'd1:    return DATA_WIDTH'(sh[15:0]);
            default: return word;
        endcase
    endfunction

    // Only the addressed lanes are replaced; the rest of the word is preserved.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old,
                                                         input logic [DATA_WIDTH-1:0] wdata,
                                                         input logic [1:0] size, input logic [1:0] off);
        logic [DATA_WIDTH-1:0] mask;
        case (size)
            2'd0:    mask = DATA_WIDTH'(8'hFF);
            2'd1:    mask = DATA_WIDTH'(16'hFFFF);
            default: mask = '1;
        endcase
        mask = mask << {off, 3'b000};
        return (old & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

`ifdef EXT_BUS_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else if (capture) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_total = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
    assign wait_total = 5'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 5'd0;
            err_o    <= 1'b0;
            intr_h_o <= 2'b00;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            intr_h_o <= (intr_h_o & ~intr_ack_i) | irq_trig_i;
            if (state == ST_RESP && req_err_p0) begin
                err_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        capture       = 1'b0;
        bus_rdy_o     = 1'b0;
        bus_data_oe_o = 1'b0;
        bus_data_o    = '0;
        case (state)
            ST_IDLE: begin
                if (bus_en_i) begin
                    capture = 1'b1;
                    if (wait_total != 5'd0) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = wait_total - 5'd1;
                    end else begin
                        state_nx = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 5'd0) begin
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt - 5'd1;
                end
            end
            ST_RESP: begin
                bus_rdy_o = 1'b1;
                state_nx  = ST_IDLE;
                if (!req_we_p0) begin
                    bus_data_oe_o = 1'b1;
                    if (!req_err_p0) begin
                        bus_data_o = lane_read(rd_word, req_size_p0, req_off_p0);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // p0: request captured in the IDLE cycle; master inputs are ignored until the next IDLE
    always_ff @(posedge clk) begin
        if (capture) begin
            req_we_p0   <= bus_we_i;
            req_size_p0 <= bus_size_i;
            req_off_p0  <= bus_addr_i[1:0];
            req_idx_p0  <= bus_addr_i[IDX_W+1:2];
            req_data_p0 <= bus_data_i;
            req_err_p0  <= access_err(bus_size_i, bus_addr_i);
        end
    end

    assign rd_word = mem[req_idx_p0];

    always_ff @(posedge clk) begin
        if (!reset && state == ST_RESP && req_we_p0 && !req_err_p0) begin
            mem[req_idx_p0] <= lane_merge(rd_word, req_data_p0, req_size_p0, req_off_p0);
        end
    end

endmodule

// File: tb/tb_ext_bus_responder.sv
// Bench for ext_bus_responder: vector table through a cycle-stamped scoreboard, plus hand sequences
// for back-to-back (zero-wait instance), interrupts and reset mid-transaction.
module tb_ext_bus_responder;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int WAITS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en, we;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    trig, ack;
    logic [DW-1:0] rdata, rdata0;
    logic          oe, oe0, rdy, rdy0, err, err0;
    logic [1:0]    intr, intr0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ext_bus_responder #(.MEM_WORDS(4096), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .reset(reset), .bus_en_i(en), .bus_we_i(we), .bus_size_i(size), .bus_addr_i(addr),
        .bus_data_i(wdata), .bus_data_o(rdata), .bus_data_oe_o(oe), .bus_rdy_o(rdy),
        .irq_trig_i(trig), .intr_h_o(intr), .intr_ack_i(ack), .err_o(err));

    ext_bus_responder #(.MEM_WORDS(4096), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus_en_i(en), .bus_we_i(we), .bus_size_i(size), .bus_addr_i(addr),
        .bus_data_i(wdata), .bus_data_o(rdata0), .bus_data_oe_o(oe0), .bus_rdy_o(rdy0),
        .irq_trig_i(trig), .intr_h_o(intr0), .intr_ack_i(ack), .err_o(err0));

    typedef struct {
        int          due;
        logic        oe;
        logic [31:0] data;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Scoreboard: every rdy must match the oldest outstanding request at its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && cyc > sb[0].due) begin
                check({sb[0].name, "_rdy_missing"}, 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (rdy) begin
                if (sb.size() == 0) begin
                    check("rdy_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
                    check({mon_e.name, "_oe"}, 32'(oe), 32'(mon_e.oe));
                    if (mon_e.oe) check({mon_e.name, "_data"}, rdata, mon_e.data);
                end
            end else if (oe) begin
                check("oe_without_rdy", 32'(oe), 32'd0);
            end
        end
    end

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic txn(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        en = 1'b1; we = v.we; size = v.size; addr = v.addr; wdata = v.wdata;
        e.due = cyc + WAITS + 1;
        e.oe = ~v.we;
        e.data = v.rdata;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        en = 1'b0; we = ~v.we; size = ~v.size; addr = ~v.addr; wdata = ~v.wdata;
        drain();
        we = 1'b0; size = 2'd0; addr = '0; wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; en = 1'b0; we = 1'b0; size = 2'd0; addr = '0; wdata = '0; trig = 2'b00; ack = 2'b00;

        vecs.push_back('{1'b1, 2'd2, 16'h0000, 32'h0BADC0DE, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 16'h0010, 32'h12345678, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 16'h0010, 32'h0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 16'h0012, 32'h777777AB, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 16'h0012, 32'h0, 32'h000012AB, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 16'h0013, 32'h0, 32'h00000012, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 16'h0014, 32'hCAFEF00D, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 16'h0016, 32'h5555BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 16'h0014, 32'h0, 32'hBEEFF00D, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 16'h0015, 32'h0, 32'h000000F0, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 16'h0014, 32'h0, 32'h0000F00D, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 16'h0011, 32'h0000005A, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 16'h0010, 32'h0, 32'h12AB5A78, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 16'h0020, 32'h11112222, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 16'h0011, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 2'd3, 16'h0000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 16'h4000, 32'hDEADDEAD, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 16'h0012, 32'hFFFFFFFF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 2'd1, 16'h0013, 32'h0000FFFF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 2'd2, 16'h0000, 32'h0, 32'h0BADC0DE, 1'b1});
        vecs.push_back('{1'b0, 2'd2, 16'h0010, 32'h0, 32'h12AB5A78, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 16'hFFFF, 32'h0, 32'h0, 1'b1});

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdy0", 32'(rdy0), 32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i], $sformatf("v%0d", i));
            @(negedge clk);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
        end

        // Zero-wait instance with en held high: a transaction every two cycles.
        mon_en = 1'b0;
        @(negedge clk);
        en = 1'b1; we = 1'b0; size = 2'd2; addr = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b_rdy_c%0d", i), 32'(rdy0), 32'(i % 2 == 1));
            if (i % 2 == 1) begin
                check($sformatf("b2b_oe_c%0d", i), 32'(oe0), 32'd1);
                check($sformatf("b2b_data_c%0d", i), rdata0, 32'h12AB5A78);
            end
            if (i == 5) en = 1'b0;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        mon_en = 1'b1;

        @(negedge clk);
        trig = 2'b01;
        #1 check("irq_registered", 32'(intr), 32'd0);
        @(negedge clk);
        trig = 2'b00;
        check("irq_set", 32'(intr), 32'b01);
        trig = 2'b01; ack = 2'b01;
        @(negedge clk);
        trig = 2'b00; ack = 2'b00;
        check("irq_trig_wins", 32'(intr), 32'b01);
        ack = 2'b10;
        @(negedge clk);
        ack = 2'b00;
        check("irq_ack_idle_line", 32'(intr), 32'b01);
        ack = 2'b01;
        @(negedge clk);
        ack = 2'b00;
        check("irq_ack_clear", 32'(intr), 32'b00);
        trig = 2'b10;
        @(negedge clk);
        trig = 2'b00;
        check("irq_line1", 32'(intr), 32'b10);

        // Reset while the write to 0x0020 sits in WAIT: no rdy, no commit.
        @(negedge clk);
        en = 1'b1; we = 1'b1; size = 2'd2; addr = 16'h0020; wdata = 32'h99990000;
        @(negedge clk);
        en = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_rdy", 32'(rdy), 32'd0);
        check("midrst_oe", 32'(oe), 32'd0);
        check("midrst_data", rdata, 32'd0);
        check("midrst_intr", 32'(intr), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        we = 1'b0; wdata = '0;
        repeat (5) @(negedge clk);
        txn('{1'b0, 2'd2, 16'h0020, 32'h0, 32'h11112222, 1'b0}, "midrst_read");
        @(negedge clk);
        check("midrst_err_after", 32'(err), 32'd0);

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ext_bus_responder.md
Name: ext_bus_responder

Overview:
- External-bus slave: the far end of the SoC's off-chip master bus (en/we/size/addr/data/rdy) plus its two-line interrupt handshake.
- Services word/half/byte reads and writes against an internal word-organised memory with programmable wait states.
- Raises interrupt requests and clears them on acknowledge.
- Serves as the board-side memory/peripheral model and as the synthesizable FPGA bring-up target.

Parameters:
MEM_WORDS, 4096, memory depth in 32-bit words (byte space 0 .. 4*MEM_WORDS-1)
ADDR_WIDTH, 16, byte-address width of bus_addr_i
DATA_WIDTH, 32, data bus width (only 32 supported)
WAIT_CYCLES, 2, wait states inserted before bus_rdy_o (0..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
bus_en_i  in  1  master transaction request
bus_we_i  in  1  1=write, 0=read
bus_size_i  in  2  0=byte, 1=half, 2=word, 3=reserved
bus_addr_i  in  ADDR_WIDTH  byte address
bus_data_i  in  DATA_WIDTH  write data, right-justified
bus_data_o  out  DATA_WIDTH  read data, right-justified, zero-extended
bus_data_oe_o  out  1  drive enable for shared data pins
bus_rdy_o  out  1  one-cycle transaction completion
irq_trig_i  in  2  per-line interrupt event pulse
intr_h_o  out  2  pending interrupt lines to the core
intr_ack_i  in  2  per-line acknowledge from the core
err_o  out  1  sticky error flag (misaligned, reserved size, out of range)

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: bus_rdy_o=0, bus_data_oe_o=0, bus_data_o=0, intr_h_o=0, err_o=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - bus_en_i=1 captures we/size/addr/data into request registers.
  - WAIT_CYCLES>0: load counter with WAIT_CYCLES-1, go to WAIT. WAIT_CYCLES=0: go straight to RESP.
- WAIT: decrement each cycle; at 0 go to RESP. Master inputs are ignored; captured values are used.
- RESP (exactly one cycle): bus_rdy_o=1.
  - Write: commit occurs in this cycle.
  - Read: bus_data_o valid and bus_data_oe_o=1 in this cycle only. bus_data_oe_o is never high on writes.
  - Next state is IDLE.
- Latency: bus_rdy_o asserts WAIT_CYCLES+1 cycles after the IDLE cycle that samples bus_en_i=1.
- Back-to-back: bus_en_i still high in the IDLE cycle after RESP starts a new transaction. Minimum period is WAIT_CYCLES+2 cycles.
- Lane rules:
  - Word uses addr[1:0]==0.
  - Half uses addr[0]==0; addr[1] selects bits [31:16] or [15:0].
  - Byte uses addr[1:0] to select the lane.
  - Write: only the selected lanes change, taken from bus_data_i low bits.
  - Read: selected lane shifted to bit 0, upper bits zero.
- Errors (misaligned access, size=3, addr >= 4*MEM_WORDS):
  - Handshake still completes with normal latency.
  - Write is suppressed; read returns 0.
  - err_o is set and held until reset.
- Interrupts, per line i:
  - pending[i] is set by irq_trig_i[i] and cleared by intr_ack_i[i].
  - Trig and ack in the same cycle: stays set (trig wins).
  - intr_h_o = pending, registered, so there is 1 cycle from trig to intr_h_o.
  - Ack on a non-pending line has no effect.
- Reset mid-transaction: FSM returns to IDLE next cycle, no write is committed, bus_rdy_o is not asserted.

Optional Feature:
- Macro: EXT_BUS_RANDOM_WAIT_EN.
- Defined:
  - Wait count per transaction = WAIT_CYCLES + lfsr[1:0].
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset.
  - LFSR advances once per accepted transaction, in the IDLE capture cycle, after sampling.
- Not defined: fixed WAIT_CYCLES; no LFSR logic present.

Test Plan:
- WAIT_CYCLES=2, word write 0x12345678 to addr 0x0010 (bus_en sampled cycle 0) -> bus_rdy_o=1 at cycle 3 only, bus_data_oe_o=0; a word read of 0x0010 then returns 0x12345678 with oe=1 for the rdy cycle.
- Byte write 0xAB to 0x0012 over that word, then half read at 0x0012 -> 0x000012AB; byte read at 0x0013 -> 0x00000012.
- Half read at 0x0011, size=3 read at 0x0000, and word write to 0x4000 (MEM_WORDS=4096) -> each completes with rdy at normal latency, reads return 0, memory unchanged, err_o=1 from the first and stays 1.
- bus_en held high for 3 transactions with WAIT_CYCLES=0 -> rdy at cycles 1, 3, 5.
- irq_trig_i=2'b01 at cycle 0 -> intr_h_o=01 at cycle 1; intr_ack_i[0] plus irq_trig_i[0] together -> stays 01; ack alone -> 00 next cycle.
- Reset asserted in WAIT during a write to 0x0020 -> no rdy, the word at 0x0020 keeps its old value, all outputs at reset values.
